// File: rtl/vram_port_arbiter.sv
// Arbitrates one registered-read RAM port between video scanout (VID) and the CPU bus.
// Build macro ARB_ROUND_ROBIN_EN swaps fixed VID priority for alternating priority.
module vram_port_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_ce,
    output logic          ram_wren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);
    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;
    typedef enum logic {OwnVid, OwnCpu} owner_e;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          vid_ack_q, vid_ack_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ram_ce_q, ram_ce_d;
    logic          ram_wren_q, ram_wren_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_data_q, ram_data_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;

    logic vid_elig, cpu_elig, vid_win, cpu_win;

    // A request still high during its own ack cycle is the old one; ignore it.
    assign vid_elig = vid_req & ~vid_ack_q;
    assign cpu_elig = cpu_req & ~cpu_ack_q;

`ifdef ARB_ROUND_ROBIN_EN
    assign cpu_win = cpu_elig & (~vid_elig | (owner_q == OwnVid));

    logic unused_wait;
    assign unused_wait = ^{wait_cnt_q, MaxWait};
`else
    // CPU only overrides VID after watching MAX_WAIT VID grants go by.
    assign cpu_win = cpu_elig & (~vid_elig | (wait_cnt_q == MaxWait));
`endif
    assign vid_win = vid_elig & ~cpu_win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        ram_ce_d    = ram_ce_q;
        ram_wren_d  = ram_wren_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        vid_rdata_d = vid_rdata_q;
        cpu_rdata_d = cpu_rdata_q;

        unique case (state_q)
            StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
                wait_cnt_d = '0;
`else
                if (cpu_win || !cpu_req) begin
                    wait_cnt_d = '0;
                end else if (vid_win && cpu_elig && (wait_cnt_q != MaxWait)) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
                if (cpu_win) begin
                    state_d    = StIssue;
                    owner_d    = OwnCpu;
                    ram_ce_d   = 1'b1;
                    ram_wren_d = cpu_we;
                    ram_addr_d = cpu_addr;
                    ram_data_d = cpu_wdata;
                end else if (vid_win) begin
                    state_d    = StIssue;
                    owner_d    = OwnVid;
                    ram_ce_d   = 1'b1;
                    ram_wren_d = 1'b0;
                    ram_addr_d = vid_addr;
                    ram_data_d = '0;
                end
            end
            StIssue: begin
                ram_ce_d   = 1'b0;
                ram_wren_d = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
                if (owner_q == OwnCpu) begin
                    cpu_rdata_d = ram_q;
                    cpu_ack_d   = 1'b1;
                end else begin
                    vid_rdata_d = ram_q;
                    vid_ack_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An ISSUE-cycle command is already on the port when reset is sampled, so it still lands.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnVid;
            wait_cnt_q  <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            vid_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            ram_ce_q    <= ram_ce_d;
            ram_wren_q  <= ram_wren_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign ram_ce    = ram_ce_q;
    assign ram_wren  = ram_wren_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed scenarios plus randomized traffic, checked by a
// cycle-level reference model and per-requester scoreboards.
module tb_vram_port_arbiter;
    localparam int unsigned AW      = 10;
    localparam int unsigned DW      = 8;
    localparam int unsigned MaxWait = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vid_req, vid_ack, cpu_req, cpu_we, cpu_ack;
    logic          ram_ce, ram_wren;
    logic [AW-1:0] vid_addr, cpu_addr, ram_addr;
    logic [DW-1:0] vid_rdata, cpu_wdata, cpu_rdata, ram_data, ram_q;
    logic          mem_clear;

    int n_tests = 0;
    int n_fail  = 0;

    txn_t vid_sb[$];
    txn_t cpu_sb[$];

    vram_port_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MAX_WAIT(MaxWait)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_rdata(vid_rdata),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ram_ce   (ram_ce),
        .ram_wren (ram_wren),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_q    (ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Environment RAM: one-cycle registered read, write-through q.
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk_sys) begin
        if (mem_clear) begin
            for (int i = 0; i < 2**AW; i++) ram_mem[i] <= '0;
        end else if (ram_ce) begin
            if (ram_wren) begin
                ram_mem[ram_addr] <= ram_data;
                ram_q             <= ram_data;
            end else begin
                ram_q <= ram_mem[ram_addr];
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a grant in cycle g puts the command on the port in g+1, latches data
    // at the end of g+2 and acks in g+3, when the port is free to grant again.
    initial begin : monitor
        int            t, g, m_wait;
        bit            g_cpu, m_last_cpu, ack_v, ack_c, vid_el, cpu_el, win_v, win_c, tie;
        txn_t          g_txn;
        logic [DW-1:0] g_exp, m_vid_rdata, m_cpu_rdata;
        logic [DW-1:0] ref_mem [2**AW];
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
        t = 0; g = -100; m_wait = 0; g_cpu = 0; m_last_cpu = 0; g_txn = '0; g_exp = '0;
        m_vid_rdata = '0; m_cpu_rdata = '0;
        @(posedge clk_sys);
        forever begin
            @(negedge clk_sys);
            ack_v = (t == g + 3) && !g_cpu;
            ack_c = (t == g + 3) && g_cpu;
            check("ram_ce", ram_ce, 32'(t == g + 1));
            check("ram_wren", ram_wren, 32'((t == g + 1) && g_cpu && g_txn.we));
            if (t == g + 1) begin
                check("ram_addr", ram_addr, 32'(g_txn.addr));
                if (g_cpu && g_txn.we) begin
                    check("ram_data", ram_data, 32'(g_txn.wdata));
                    ref_mem[g_txn.addr] = g_txn.wdata;
                    g_exp = g_txn.wdata;
                end else begin
                    g_exp = ref_mem[g_txn.addr];
                end
            end
            check("vid_ack", vid_ack, 32'(ack_v));
            check("cpu_ack", cpu_ack, 32'(ack_c));
            check("vid_rdata", vid_rdata, 32'(m_vid_rdata));
            check("cpu_rdata", cpu_rdata, 32'(m_cpu_rdata));
            if (reset) begin
                g = -100; m_wait = 0; m_last_cpu = 0; m_vid_rdata = '0; m_cpu_rdata = '0;
            end else begin
                if (t == g + 2) begin
                    if (g_cpu) m_cpu_rdata = g_exp;
                    else       m_vid_rdata = g_exp;
                end
                if (t >= g + 3) begin
                    vid_el = vid_req && !ack_v;
                    cpu_el = cpu_req && !ack_c;
                    tie    = vid_el && cpu_el;
`ifdef ARB_ROUND_ROBIN_EN
                    win_c = tie ? !m_last_cpu : cpu_el;
`else
                    win_c = tie ? (m_wait == int'(MaxWait)) : cpu_el;
`endif
                    win_v = vid_el && !win_c;
`ifndef ARB_ROUND_ROBIN_EN
                    if (win_c || !cpu_req) m_wait = 0;
                    else if (win_v && cpu_el && m_wait < int'(MaxWait)) m_wait++;
`endif
                    if (win_c || win_v) begin
                        g = t; g_cpu = win_c; m_last_cpu = win_c;
                        n_tests++;
                        if ((win_c ? cpu_sb.size() : vid_sb.size()) == 0) begin
                            n_fail++;
                            $display("FAIL sb_empty: got grant with no queued request, cpu=%0d",
                                     win_c);
                            g_txn = '0;
                        end else begin
                            g_txn = win_c ? cpu_sb.pop_front() : vid_sb.pop_front();
                        end
                    end
                end
            end
            t++;
        end
    end

    task automatic vid_driver(input int n, input int gap_max);
        txn_t tx;
        int   gap, wt;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gap_max, 0);
            if (gap > 0) begin
                vid_req = 1'b0;
                repeat (gap) @(posedge clk_sys);
                #1;
            end
            tx.addr = AW'($urandom_range(15, 0)); tx.we = 1'b0; tx.wdata = '0;
            vid_addr = tx.addr;
            vid_req  = 1'b1;
            vid_sb.push_back(tx);
            wt = 0;
            do begin
                @(negedge clk_sys);
                wt++;
            end while (!vid_ack && wt < 40);
            check("vid_ack_timeout", 32'(vid_ack), 32'd1);
            @(posedge clk_sys);
            #1;
        end
        vid_req = 1'b0;
    endtask

    task automatic cpu_driver(input int n, input int gap_max);
        txn_t tx;
        int   gap, wt;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gap_max, 0);
            if (gap > 0) begin
                cpu_req = 1'b0;
                repeat (gap) @(posedge clk_sys);
                #1;
            end
            tx.addr = AW'($urandom_range(15, 0));
            tx.we = 1'($urandom_range(1, 0));
            tx.wdata = DW'($urandom);
            cpu_addr = tx.addr; cpu_we = tx.we; cpu_wdata = tx.wdata;
            cpu_req  = 1'b1;
            cpu_sb.push_back(tx);
            wt = 0;
            do begin
                @(negedge clk_sys);
                wt++;
            end while (!cpu_ack && wt < 40);
            check("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
            @(posedge clk_sys);
            #1;
        end
        cpu_req = 1'b0;
    endtask

    // One isolated transaction from an idle port, req held through the ack cycle.
    task automatic directed(input bit is_cpu, input logic [AW-1:0] addr, input bit we,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
        txn_t tx;
        int   ce_cnt, ack_cnt, ack_cyc;
        tx.addr = addr; tx.we = we; tx.wdata = wdata;
        if (is_cpu) begin
            cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; cpu_req = 1'b1;
            cpu_sb.push_back(tx);
        end else begin
            vid_addr = addr; vid_req = 1'b1;
            vid_sb.push_back(tx);
        end
        ce_cnt = 0; ack_cnt = 0; ack_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_sys);
            if (ram_ce) ce_cnt++;
            if (k == 1) begin
                check("dir_ram_ce", 32'(ram_ce), 32'd1);
                check("dir_ram_wren", 32'(ram_wren), 32'(we));
                check("dir_ram_addr", 32'(ram_addr), 32'(addr));
                if (we) check("dir_ram_data", 32'(ram_data), 32'(wdata));
            end
            if (is_cpu ? cpu_ack : vid_ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = k;
                check("dir_rdata", 32'(is_cpu ? cpu_rdata : vid_rdata), 32'(exp_rdata));
                check("dir_other_ack", 32'(is_cpu ? vid_ack : cpu_ack), 32'd0);
            end
            if (k == 3) begin
                @(posedge clk_sys);
                #1;
                cpu_req = 1'b0;
                vid_req = 1'b0;
            end
        end
        check("dir_ack_cycle", 32'(ack_cyc), 32'd3);
        check("dir_ce_pulses", 32'(ce_cnt), 32'd1);
        check("dir_ack_pulses", 32'(ack_cnt), 32'd1);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vid_ack"}, 32'(vid_ack), 32'd0);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_ram_ce"}, 32'(ram_ce), 32'd0);
        check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
        check({tag, "_vid_rdata"}, 32'(vid_rdata), 32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        txn_t tx;
        reset = 1'b1; mem_clear = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0; mem_clear = 1'b0;
        @(negedge clk_sys);
        check_all_zero("reset");
        @(posedge clk_sys);
        #1;

        directed(1'b1, 10'h155, 1'b1, 8'hA5, 8'hA5);
        directed(1'b0, 10'h155, 1'b0, 8'h00, 8'hA5);
        @(negedge clk_sys);
        check("cpu_rdata_held", 32'(cpu_rdata), 32'hA5);
        @(posedge clk_sys);
        #1;

        // Both requesters back to back with no idle gaps.
        fork
            vid_driver(12, 0);
            cpu_driver(12, 0);
        join
        repeat (4) @(posedge clk_sys);
        #1;

        // Reset lands while a CPU write sits in ISSUE.
        tx.addr = 10'h3FF; tx.we = 1'b1; tx.wdata = 8'h5A;
        cpu_addr = tx.addr; cpu_we = 1'b1; cpu_wdata = tx.wdata; cpu_req = 1'b1;
        cpu_sb.push_back(tx);
        @(posedge clk_sys);
        #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk_sys);
        check("rst_issue_ce", 32'(ram_ce), 32'd1);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        @(negedge clk_sys);
        check_all_zero("rst_mid");
        check("rst_write_landed", 32'(ram_mem[10'h3FF]), 32'h5A);
        repeat (3) begin
            @(negedge clk_sys);
            check("rst_no_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        @(posedge clk_sys);
        #1;
        directed(1'b0, 10'h3FF, 1'b0, 8'h00, 8'h5A);

        fork
            vid_driver(100, 3);
            cpu_driver(100, 3);
        join
        repeat (6) @(posedge clk_sys);
        #1;
        check("vid_sb_drained", 32'(vid_sb.size()), 32'd0);
        check("cpu_sb_drained", 32'(cpu_sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
